// File: rtl/sprite_pkg.sv
// Shared sprite ROM types and widths used by the sprite fetch path.
// Pure declarations: no latency and no flow control of its own.
package sprite_pkg;
   localparam int SPRITE_ADDR_W = 12;
   localparam int SPRITE_DATA_W = 8;
   localparam int REQ_ID_W      = 3;

   typedef logic [SPRITE_ADDR_W-1:0] sprite_addr_t;
   typedef logic [SPRITE_DATA_W-1:0] sprite_data_t;
   typedef logic [REQ_ID_W-1:0]      req_id_t;
endpackage

// File: rtl/sprite_rom_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Zero latency; no backpressure, an empty request vector simply yields no grant.
module rr_arbiter
   import sprite_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req_i,
   input  logic [$clog2(N_REQ)-1:0] ptr_i,
   output logic [N_REQ-1:0]         gnt_o,
   output logic [$clog2(N_REQ)-1:0] id_o,
   output logic                     any_o
);
   localparam int ID_W = $clog2(N_REQ);

   logic [ID_W-1:0] idx;
   logic            found;
   int              pos;

   always_comb begin
      gnt_o = '0;
      id_o  = '0;
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         pos = int'(ptr_i) + k;
         if (pos >= N_REQ) begin
            pos = pos - N_REQ;
         end
         idx = ID_W'(pos);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            id_o       = idx;
            gnt_o[idx] = 1'b1;
         end
      end
      any_o = found;
   end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite ROM: one grant per cycle, tagged response ROM_LAT+1 cycles later, no response backpressure.
// SPRITE_ARB_PLAYER_PRIO_EN gives requester 0 strict priority; others keep round-robin among 1..N_REQ-1.
module sprite_rom_arbiter
   import sprite_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = SPRITE_ADDR_W,
   parameter int DATA_W  = SPRITE_DATA_W,
   parameter int ROM_LAT = 2
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [N_REQ-1:0]          req_i,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
   output logic [N_REQ-1:0]          gnt_o,
   output logic [ADDR_W-1:0]         rom_addr_o,
   input  logic [DATA_W-1:0]         rom_data_i,
   output logic                      rsp_valid_o,
   output logic [$clog2(N_REQ)-1:0]  rsp_id_o,
   output logic [DATA_W-1:0]         rsp_data_o
);
   localparam int              ID_W    = $clog2(N_REQ);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
   localparam logic [ID_W-1:0] PTR_FIRST = ID_W'(1);
`else
   localparam logic [ID_W-1:0] PTR_FIRST = '0;
`endif

   logic [ID_W-1:0]              ptr_q, ptr_d;
   logic [ADDR_W-1:0]            rom_addr_q, rom_addr_d;
   logic [ROM_LAT:0]             vld_q, vld_d;
   logic [ROM_LAT:0][ID_W-1:0]   id_q, id_d;

   logic [N_REQ-1:0] rr_req, rr_gnt, gnt;
   logic [ID_W-1:0]  rr_id, win_id;
   logic             rr_any, rr_owns_grant;

`ifdef SPRITE_ARB_PLAYER_PRIO_EN
   // The player never enters the rotation; it wins outright below.
   assign rr_req = req_i & ~N_REQ'(1);
`else
   assign rr_req = req_i;
`endif

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr (
      .req_i (rr_req),
      .ptr_i (ptr_q),
      .gnt_o (rr_gnt),
      .id_o  (rr_id),
      .any_o (rr_any)
   );

   always_comb begin
      gnt           = rr_gnt;
      win_id        = rr_id;
      rr_owns_grant = rr_any;
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
      if (req_i[0]) begin
         gnt           = N_REQ'(1);
         win_id        = '0;
         rr_owns_grant = 1'b0;
      end
`endif
      if (reset_i) begin
         gnt           = '0;
         rr_owns_grant = 1'b0;
      end
   end

   always_comb begin
      ptr_d      = ptr_q;
      rom_addr_d = rom_addr_q;
      if (rr_owns_grant) begin
         ptr_d = (rr_id == LAST_ID) ? PTR_FIRST : rr_id + ID_W'(1);
      end
      if (|gnt) begin
         rom_addr_d = req_addr_i[win_id*ADDR_W +: ADDR_W];
      end
      // Stage 0 is the grant cycle's tag; stage ROM_LAT lines up with rom_data.
      vld_d = {vld_q[ROM_LAT-1:0], |gnt};
      id_d  = {id_q[ROM_LAT-1:0], win_id};
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_q      <= PTR_FIRST;
         rom_addr_q <= '0;
         vld_q      <= '0;
         id_q       <= '0;
      end else begin
         ptr_q      <= ptr_d;
         rom_addr_q <= rom_addr_d;
         vld_q      <= vld_d;
         id_q       <= id_d;
      end
   end

   assign gnt_o       = gnt;
   assign rom_addr_o  = rom_addr_q;
   assign rsp_valid_o = vld_q[ROM_LAT];
   assign rsp_id_o    = id_q[ROM_LAT];
   assign rsp_data_o  = rom_data_i;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with N_REQ=4, ROM_LAT=2 and a ROM returning addr[7:0].
module tb_sprite_rom_arbiter;
   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [47:0] req_addr;
   logic [3:0]  gnt;
   logic [11:0] rom_addr;
   logic [7:0]  rom_data;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_data;
   logic [7:0]  rom_q1, rom_q2;

   int checks   = 0;
   int failures = 0;

   sprite_rom_arbiter #(
      .N_REQ   (4),
      .ADDR_W  (12),
      .DATA_W  (8),
      .ROM_LAT (2)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .req_i       (req),
      .req_addr_i  (req_addr),
      .gnt_o       (gnt),
      .rom_addr_o  (rom_addr),
      .rom_data_i  (rom_data),
      .rsp_valid_o (rsp_valid),
      .rsp_id_o    (rsp_id),
      .rsp_data_o  (rsp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Two-cycle synchronous ROM: data = addr[7:0].
   always_ff @(posedge clk) begin
      rom_q1 <= rom_addr[7:0];
      rom_q2 <= rom_q1;
   end
   assign rom_data = rom_q2;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int i, input logic [11:0] a);
      req_addr[i*12 +: 12] = a;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset    = 1'b1;
      req      = 4'h0;
      req_addr = '0;

      tick();
      req = 4'hF;
      #2;
      chk("rst_gnt",      32'(gnt), 0);
      chk("rst_rom_addr", 32'(rom_addr), 0);
      chk("rst_rsp_vld",  32'(rsp_valid), 0);
      chk("rst_rsp_id",   32'(rsp_id), 0);
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
      chk("rst_ptr",      32'(dut.ptr_q), 1);

      for (int k = 0; k < 6; k++) begin
         tick();
         reset = 1'b0;
         req   = 4'hF;
         set_addr(0, 12'h040 + 12'(k));
         #2;
         chk("prio_gnt", 32'(gnt), 1);
         if (k >= 3) begin
            chk("prio_rsp_vld", 32'(rsp_valid), 1);
            chk("prio_rsp_id",  32'(rsp_id), 0);
         end
      end
      chk("prio_ptr_hold", 32'(dut.ptr_q), 1);
      for (int k = 0; k < 4; k++) begin
         tick();
         req = 4'b1110;
         #2;
         chk("prio_rr_gnt", 32'(gnt), (k == 0) ? 2 : (k == 1) ? 4 : (k == 2) ? 8 : 2);
      end
`else
      chk("rst_ptr",      32'(dut.ptr_q), 0);

      // Single request from requester 2
      tick();
      reset = 1'b0;
      req   = 4'b0100;
      set_addr(2, 12'h0A5);
      #2;
      chk("t1_gnt", 32'(gnt), 4);
      tick();
      req = 4'h0;
      #2;
      chk("t1_rom_addr", 32'(rom_addr), 'h0A5);
      chk("t1_ptr",      32'(dut.ptr_q), 3);
      chk("t1_gnt_idle", 32'(gnt), 0);
      tick();
      #2;
      chk("t1_rsp_early", 32'(rsp_valid), 0);
      tick();
      #2;
      chk("t1_rsp_vld",  32'(rsp_valid), 1);
      chk("t1_rsp_id",   32'(rsp_id), 2);
      chk("t1_rsp_data", 32'(rsp_data), 'hA5);
      tick();
      #2;
      chk("t1_rsp_once", 32'(rsp_valid), 0);

      // Wrap-around from ptr=3
      req = 4'b0011;
      set_addr(0, 12'h021);
      set_addr(1, 12'h022);
      #2;
      chk("t3_gnt0", 32'(gnt), 1);
      tick();
      req = 4'b0010;
      #2;
      chk("t3_ptr1", 32'(dut.ptr_q), 1);
      chk("t3_gnt1", 32'(gnt), 2);
      tick();
      req = 4'h0;
      #2;
      chk("t3_ptr2", 32'(dut.ptr_q), 2);

      // Reset with two grants in flight
      tick();
      req = 4'b0100;
      set_addr(2, 12'h031);
      #2;
      chk("t4_gnt_c0", 32'(gnt), 4);
      tick();
      req = 4'b1000;
      set_addr(3, 12'h032);
      #2;
      chk("t4_gnt_c1", 32'(gnt), 8);
      tick();
      reset = 1'b1;
      req   = 4'h0;
      #2;
      chk("t4_gnt_rst", 32'(gnt), 0);
      chk("t4_rsp_c2",  32'(rsp_valid), 0);
      tick();
      reset = 1'b0;
      #2;
      chk("t4_rom_addr", 32'(rom_addr), 0);
      chk("t4_ptr",      32'(dut.ptr_q), 0);
      chk("t4_rsp_c3",   32'(rsp_valid), 0);
      for (int c = 4; c <= 6; c++) begin
         tick();
         #2;
         chk("t4_rsp_flushed", 32'(rsp_valid), 0);
      end

      // All four requesting: rotating grants, in-order responses
      for (int i = 0; i < 4; i++) set_addr(i, 12'(16 + i));
      for (int k = 0; k <= 10; k++) begin
         tick();
         req = (k < 8) ? 4'hF : 4'h0;
         #2;
         chk("t2_gnt", 32'(gnt), (k < 8) ? (1 << (k % 4)) : 0);
         if (k >= 3) begin
            chk("t2_rsp_vld",  32'(rsp_valid), 1);
            chk("t2_rsp_id",   32'(rsp_id), (k - 3) % 4);
            chk("t2_rsp_data", 32'(rsp_data), 'h10 + ((k - 3) % 4));
         end
      end
      tick();
      #2;
      chk("t2_rsp_end", 32'(rsp_valid), 0);

      // Idle: everything holds
      for (int c = 0; c < 10; c++) begin
         tick();
         #2;
         chk("t6_gnt",      32'(gnt), 0);
         chk("t6_rsp_vld",  32'(rsp_valid), 0);
         chk("t6_rom_addr", 32'(rom_addr), 'h013);
         chk("t6_ptr",      32'(dut.ptr_q), 0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one synchronous sprite ROM among up to N_REQ pixel-address requesters (player, enemies, bullets). Requesters present a ROM address (e.g. the player's 12-bit sprite address); the arbiter grants one per cycle and drives the ROM address. It returns the ROM data to the winner, tagged with the requester ID, after a fixed latency. It sits between the per-object sprite modules and the single sprite ROM, upstream of the color mapper.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 12, ROM address width
- DATA_W, 8, ROM data width
- ROM_LAT, 2, ROM read latency in cycles from rom_addr to rom_data (1..4)

Ports:
- Clk  in  1  system clock. One clock domain; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester read request, level
- req_addr  in  N_REQ*ADDR_W  packed addresses; slice i = requester i
- gnt  out  N_REQ  one-hot grant, combinational, at most one bit set
- rom_addr  out  ADDR_W  registered address to ROM
- rom_data  in  DATA_W  ROM read data
- rsp_valid  out  1  response valid
- rsp_id  out  $clog2(N_REQ)  requester that owns rsp_data
- rsp_data  out  DATA_W  equals rom_data, qualified by rsp_valid

## Operation
- Round-robin pointer ptr, with reset value 0.
- The winner is the first i with req[i]=1, searching from ptr upward and wrapping modulo N_REQ.
- gnt[winner]=1 in the same cycle. No winner → gnt=0.
- On a grant edge:
  - rom_addr ← req_addr[winner]
  - ptr ← (winner+1) mod N_REQ
- Without a grant, rom_addr and ptr hold.
- Handshake:
  - A requester holds req and its address stable until it sees gnt.
  - gnt is a single-cycle acceptance.
  - A requester may re-assert req in the next cycle for a new address. It competes normally and is not favoured.
- Response delay line, ROM_LAT+1 stages deep, carrying (valid, id).
  - Stage 0 loads (|gnt, winner).
  - Output stage drives rsp_valid and rsp_id.
- No backpressure on responses. Consumers must capture on rsp_valid.
- Starvation bound: a continuously requesting requester is granted within N_REQ cycles.
- All-requesters-active: one grant per cycle, in rotating order 0,1,...,N_REQ-1,0,...
- Reset:
  - gnt=0 (req ignored during Reset)
  - rom_addr=0
  - ptr=0
  - rsp_valid=0, rsp_id=0
  - all delay-line stages cleared
- Reset mid-operation: in-flight responses are discarded. No rsp_valid appears for grants issued before Reset.

## Timing
- Request granted in cycle t → rom_addr valid in cycle t+1 → rom_data valid in cycle t+1+ROM_LAT.
- rsp_valid=1 and rsp_id=winner in cycle t+1+ROM_LAT, for exactly one cycle per grant.
- Grant-to-response latency is fixed at ROM_LAT+1 cycles.
- Throughput is one response per cycle. Back-to-back grants give back-to-back rsp_valid in grant order.
- gnt is combinational from req and ptr. It has no combinational path from rom_data.
- rsp_data is a wire from rom_data, with no added register.

## Configuration
- SPRITE_ARB_PLAYER_PRIO_EN defined:
  - Requester 0 (the player) has strict priority. Whenever req[0]=1, it is granted.
  - The remaining requesters round-robin among themselves. ptr ranges 1..N_REQ-1, with reset value 1.
  - ptr is not updated on requester-0 grants.
- SPRITE_ARB_PLAYER_PRIO_EN undefined: pure round robin across all N_REQ requesters, as above.
- Latency and the response path are identical in both builds.

## Structure
- Shared package sprite_pkg:
  - SPRITE_ADDR_W=12, SPRITE_DATA_W=8
  - typedef sprite_addr_t, sprite_data_t
  - typedef req_id_t for a 3-bit ID
- Sub-module rr_arbiter: purely combinational one-hot grant from req and ptr, plus the encoded winner ID.
- Pointer register, address register and response delay line stay in sprite_rom_arbiter.

## Test plan
Benches use N_REQ=4, ROM_LAT=2 and a behavioral ROM where data = addr[7:0], unless noted.

1. Reset then single request: req=4'b0100, addr2=12'h0A5.
   - gnt=4'b0100 in cycle 0.
   - rom_addr=12'h0A5 in cycle 1.
   - rsp_valid=1, rsp_id=2, rsp_data=8'hA5 in cycle 3.
   - ptr=3 afterwards.
2. All four requesting continuously, addresses 0x10..0x13.
   - Grants in cycles 0..7 are 0,1,2,3,0,1,2,3.
   - rsp_id sequence is identical, starting in cycle 3.
   - rsp_data is 10,11,12,13,...
3. Wrap-around: ptr=3 with req=4'b0011.
   - gnt=4'b0001, then ptr=1, then gnt=4'b0010.
4. Reset asserted in cycle 2, after grants in cycles 0 and 1.
   - rsp_valid stays 0 through cycle 6.
   - rom_addr=0 and ptr=0 after Reset.
5. Build with SPRITE_ARB_PLAYER_PRIO_EN, req=4'b1111 held for 6 cycles.
   - Grants are 0,0,0,0,0,0.
   - Then req[0] drops: grants are 1,2,3,1.
6. Idle: req=0 for 10 cycles.
   - gnt=0 and rsp_valid=0 throughout.
   - rom_addr and ptr hold.
